block_dispatcher: RTL
=====================

// Module: block_dispatcher
// PURPOSE
//  Kernel-level block dispatcher; drives the start/done handshake of each core's scheduler.
//  On start it splits thread_count into blocks of THREADS_PER_BLOCK threads.
//  It issues one block at a time to free cores, collects per-core completion and pulses done.
//  Sits between the host/device-control registers and the NUM_CORES compute cores.
// PARAMETERS
//  NUM_CORES         2  number of compute cores driven (1..8)
//  THREADS_PER_BLOCK 4  threads per full block; equals each core's NUM_THREADS
// PORTS
//  clk                input  1           clock, all logic on rising edge
//  reset              input  1           asynchronous, active-high; clears all state
//  start              input  1           kernel launch pulse; sampled only in IDLE
//  thread_count       input  8           total kernel threads; sampled with start
//  busy               output 1           high from accepted start until done
//  done               output 1           kernel complete; held until next start accepted
//  core_start         output NUM_CORES   one-cycle block-issue pulse per core
//  core_block_id      output NUM_CORES*8 per-core block id; valid with, and held after, core_start
//  core_thread_count  output NUM_CORES*8 per-core thread count of issued block
//  core_done          input  NUM_CORES   per-core level; rises on RET, falls after next core_start
//  kernel_cycles      output 32          only with BLOCK_DISPATCHER_PERF_EN
// BEHAVIOUR
//  Reset values: busy=0, done=0, core_start=0, core_block_id=0, core_thread_count=0.
//   kernel_cycles=0; FSM=IDLE; all core_free=1; core_done_q=0.
//  States: IDLE(00), DISPATCH(01). Transitions:
//   IDLE: on start, latch total_blocks=ceil(thread_count/TPB) and rem=thread_count%TPB.
//    Also clear next_block, set busy=1, clear done, go to DISPATCH.
//   DISPATCH: when next_block==total_blocks and all core_free=1: done=1, busy=0, go to IDLE.
//   start while not in IDLE is ignored; done is not cleared by it.
//  Issue rule, per DISPATCH edge: if next_block<total_blocks and any core_free:
//   k = lowest-index free core; at most one issue per cycle.
//   core_start[k]=1 for exactly one cycle; core_block_id[k]=next_block; core_free[k]=0.
//   core_thread_count[k]=(next_block==total_blocks-1 && rem!=0) ? rem : TPB.
//   next_block increments.
//  Completion: core_done_q registers core_done. Rising edge on a busy core sets core_free[k]=1.
//   That core is eligible for issue on the next edge; level-high core_done is never a completion.
//  Latency: start sampled at edge E; first core_start visible after edge E+1.
//   done rises one edge after the last core_done rising edge is registered.
//  thread_count=0: total_blocks=0, done=1 at edge E+1; no core_start is issued.
//  Simultaneous completions: all freed in the same edge; reissued lowest index first, one per cycle.
//  Reset mid-kernel: immediate return to reset values; cores share reset; no partial resume.
//  Widths: block ids 8 bit; max 255 threads yields 64 blocks; no overflow.
// CONFIGURATION
//  BLOCK_DISPATCHER_PERF_EN defined:
//   kernel_cycles clears on accepted start and increments each DISPATCH cycle.
//   It freezes at done and saturates at 32'hFFFF_FFFF.
//  BLOCK_DISPATCHER_PERF_EN undefined: kernel_cycles port and counter are absent.
// STRUCTURE
//  gpu_pkg: dispatcher state encoding, BLOCK_ID_W=8, CORE_DONE/IDLE encodings shared with scheduler.
//  Sub-module lowest_free_pick: combinational priority encoder.
//   NUM_CORES-bit free mask in; index out plus any_free.
//  Per-core slot registers (free, done_q, block_id, count) in a generate loop.
// TESTING
//  1. NUM_CORES=2, TPB=4, thread_count=10.
//     -> blk0 to core0 (cnt 4), blk1 to core1 (cnt 4).
//     Core1 done first -> blk2 to core1 (cnt 2); done only after all three complete.
//  2. thread_count=8 -> exactly two issues, both cnt 4.
//     thread_count=0 -> done one edge after start, core_start never high.
//  3. Both core_done rise same cycle with 2 blocks left.
//     -> core0 issued next edge, core1 the edge after.
//  4. start pulsed mid-kernel -> ignored: block ids continue, total unchanged.
//     core_done held high after done -> no extra issue.
//  5. Reset asserted between clk edges mid-DISPATCH -> outputs zero immediately.
//     A new start with 5 threads then completes normally (cnts 4,1).
//  6. PERF_EN build: kernel_cycles equals bench-counted DISPATCH cycles for test 1.
//     Non-PERF build compiles without the port.

Source files
------------

// File: rtl/block_dispatcher_pkg.sv
// Shared types and constants for the kernel block dispatcher.
// State encodings here are also used by the per-core scheduler.
package block_dispatcher_pkg;

    localparam int BLOCK_ID_W = 8;
    localparam int COUNT_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_DISPATCH = 2'b01
    } disp_state_e;

    typedef enum logic [1:0] {
        CORE_IDLE = 2'b00,
        CORE_DONE = 2'b11
    } core_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/block_dispatcher_lowest_free_pick.sv
// Combinational priority encoder: returns the lowest-index set bit of the
// free mask and whether any bit is set.
module block_dispatcher_lowest_free_pick
    import block_dispatcher_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int IDX_W     = idx_width(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] free_mask,
    output logic [IDX_W-1:0]     idx,
    output logic                 any_free
);

    always_comb begin
        idx      = '0;
        any_free = 1'b0;
        // Scan downward so the lowest set index wins.
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                idx      = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/block_dispatcher.sv
// Kernel block dispatcher: splits a launch into fixed-size blocks and issues
// them one per cycle to free cores. Optional BLOCK_DISPATCHER_PERF_EN adds kernel_cycles.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start; done held from the previous kernel
// DISPATCH | issuing blocks to free cores and collecting completions
module block_dispatcher
    import block_dispatcher_pkg::*;
#(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [7:0]                      thread_count,
    output logic                            busy,
    output logic                            done,
    output logic [NUM_CORES-1:0]            core_start,
    output logic [NUM_CORES*BLOCK_ID_W-1:0] core_block_id,
    output logic [NUM_CORES*COUNT_W-1:0]    core_thread_count,
    input  logic [NUM_CORES-1:0]            core_done
`ifdef BLOCK_DISPATCHER_PERF_EN
    ,
    output logic [31:0]                     kernel_cycles
`endif
);

    localparam int IDX_W = idx_width(NUM_CORES);
    localparam logic [8:0] TPB_W = 9'(THREADS_PER_BLOCK);
    localparam logic [COUNT_W-1:0] TPB_C = COUNT_W'(THREADS_PER_BLOCK);

    disp_state_e state, state_nxt;

    logic [BLOCK_ID_W-1:0] total_blocks;
    logic [COUNT_W-1:0]    rem;
    logic [BLOCK_ID_W-1:0] next_block;
    logic [NUM_CORES-1:0]  core_free;
    logic [IDX_W-1:0]      pick_idx;
    logic                  any_free;
    logic                  accept;
    logic                  finish;
    logic                  issue;
    logic [COUNT_W-1:0]    issue_cnt;
    logic [BLOCK_ID_W-1:0] total_blocks_d;
    logic [COUNT_W-1:0]    rem_d;

    assign total_blocks_d = BLOCK_ID_W'(({1'b0, thread_count} + TPB_W - 9'd1) / TPB_W);
    assign rem_d          = thread_count % TPB_C;

    block_dispatcher_lowest_free_pick #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_pick (
        .free_mask (core_free),
        .idx       (pick_idx),
        .any_free  (any_free)
    );

    assign accept = (state == ST_IDLE) && start;
    assign finish = (state == ST_DISPATCH) && (next_block == total_blocks) && (&core_free);
    assign issue  = (state == ST_DISPATCH) && (next_block < total_blocks) && any_free;

    // Only the final block of a kernel can be short.
    assign issue_cnt = ((next_block == total_blocks - 8'd1) && (rem != '0)) ? rem : TPB_C;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start)  state_nxt = ST_DISPATCH;
            ST_DISPATCH: if (finish) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_blocks <= '0;
            rem          <= '0;
            next_block   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (accept) begin
                total_blocks <= total_blocks_d;
                rem          <= rem_d;
                next_block   <= '0;
                busy         <= 1'b1;
                done         <= 1'b0;
            end else if (finish) begin
                busy <= 1'b0;
                done <= 1'b1;
            end else if (issue) begin
                next_block <= next_block + 8'd1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_slot
        logic                  free_r;
        logic                  done_q_r;
        logic                  start_r;
        logic [BLOCK_ID_W-1:0] id_r;
        logic [COUNT_W-1:0]    cnt_r;
        logic                  sel;
        logic                  rise;

        assign sel  = issue && (pick_idx == IDX_W'(k));
        // A level that stays high across a reissue is not a new completion.
        assign rise = core_done[k] && !done_q_r && !free_r;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                free_r   <= 1'b1;
                done_q_r <= 1'b0;
                start_r  <= 1'b0;
                id_r     <= '0;
                cnt_r    <= '0;
            end else begin
                done_q_r <= core_done[k];
                start_r  <= sel;
                if (sel) begin
                    free_r <= 1'b0;
                    id_r   <= next_block;
                    cnt_r  <= issue_cnt;
                end else if (rise) begin
                    free_r <= 1'b1;
                end
            end
        end

        assign core_free[k]                                  = free_r;
        assign core_start[k]                                 = start_r;
        assign core_block_id[k*BLOCK_ID_W +: BLOCK_ID_W]     = id_r;
        assign core_thread_count[k*COUNT_W +: COUNT_W]       = cnt_r;
    end

`ifdef BLOCK_DISPATCHER_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kernel_cycles <= '0;
        end else if (accept) begin
            kernel_cycles <= '0;
        end else if ((state == ST_DISPATCH) && (kernel_cycles != 32'hFFFF_FFFF)) begin
            kernel_cycles <= kernel_cycles + 32'd1;
        end
    end
`endif

endmodule
